// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared board geometry, piece codes and controller state types
//
// Purpose: common definitions for the cursor controller, layout matrix and pixel path.
// Ports: none (package).

package chess_pkg;

    localparam int SQUARE_WIDTH  = 8;
    localparam int CHESS_SQUARES = 64;
    localparam int SQ_IDX_W      = $clog2(CHESS_SQUARES);

    typedef logic [SQ_IDX_W-1:0] square_t;
    typedef logic [2:0]          piece_t;

    localparam piece_t EMPTY  = 3'd0;
    localparam piece_t PAWN   = 3'd1;
    localparam piece_t KNIGHT = 3'd2;
    localparam piece_t BISHOP = 3'd3;
    localparam piece_t ROOK   = 3'd4;
    localparam piece_t QUEEN  = 3'd5;
    localparam piece_t KING   = 3'd6;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECTED = 2'd1,
        REQUEST  = 2'd2
    } ctrl_state_e;

    // Row and column of a square index (row*SQUARE_WIDTH + col, row 0 at top).
    function automatic logic [2:0] sq_row(square_t sq);
        return sq[5:3];
    endfunction

    function automatic logic [2:0] sq_col(square_t sq);
        return sq[2:0];
    endfunction

endpackage

// File: rtl/chess_cursor_controller_if.sv
// rtl/chess_cursor_controller_if.sv - move request valid/ready channel to the layout matrix
//
// Purpose: carries one move request (source and destination squares) per handshake.
// Signals:
//   moveValid  request pending (driven by the controller)
//   moveSrc    source square, stable while moveValid
//   moveDst    destination square, stable while moveValid
//   moveReady  layout matrix accepts the move
// Modports: master = controller side, slave = layout matrix side.

interface chess_cursor_controller_if;
    import chess_pkg::*;

    logic    moveValid;
    square_t moveSrc;
    square_t moveDst;
    logic    moveReady;

    modport master (
        output moveValid,
        output moveSrc,
        output moveDst,
        input  moveReady
    );

    modport slave (
        input  moveValid,
        input  moveSrc,
        input  moveDst,
        output moveReady
    );

endinterface

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - 2-FF synchroniser plus hold-time debouncer with change pulse
//
// Purpose: accepts a new level only after the synchronised input has differed from
//          the current debounced level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clock     system clock
//   resetApp  asynchronous active-high reset
//   raw_i     raw asynchronous input
//   level_o   debounced level (resets to RESET_LEVEL)
//   edge_o    one-cycle pulse in the first cycle a new level is shown on level_o;
//             rise = edge_o & level_o, fall = edge_o & ~level_o

module key_debouncer #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clock,
    input  logic resetApp,
    input  logic raw_i,
    output logic level_o,
    output logic edge_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_q, edge_d;

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
        end
    end

    // The counter tracks how many consecutive cycles the synchronised level has
    // disagreed with the accepted level; any agreement (a bounce) clears it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        edge_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                edge_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign edge_o  = edge_q;

endmodule

// File: rtl/chess_cursor_controller.sv
// rtl/chess_cursor_controller.sv - board keys and lock switch to cursor/selection/move events
//
// Purpose: holds the 8x8 cursor, the selected source square and the side to move;
//          issues one move request per completed selection, then passes the turn.
// Ports:
//   clock, resetApp                    clock, asynchronous active-high reset
//   KeyLeft/KeyUp/KeyDown/KeyRight     raw active-low push keys
//   LockSwitch                         raw slide switch, 1 = lock
//   cursorPiece, cursorColour          piece at cursorIdx from the layout matrix
//   cursorIdx                          cursor square (row*8+col)
//   selectIdx, selectValid             locked source square
//   move_bus                           move request channel (master side)
//   Player                             side to move, 0 = white, 1 = black

module chess_cursor_controller
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int CURSOR_RESET_IDX = 52
) (
    input  logic                      clock,
    input  logic                      resetApp,
    input  logic                      KeyLeft,
    input  logic                      KeyUp,
    input  logic                      KeyDown,
    input  logic                      KeyRight,
    input  logic                      LockSwitch,
    input  logic [2:0]                cursorPiece,
    input  logic                      cursorColour,
    output logic [5:0]                cursorIdx,
    output logic [5:0]                selectIdx,
    output logic                      selectValid,
    chess_cursor_controller_if.master move_bus,
    output logic                      Player
);

    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_UP    = 2;
    localparam int K_DOWN  = 3;

    localparam logic [2:0] EDGE_HI = 3'(SQUARE_WIDTH - 1);

    // ---------------------------------------------------------------- inputs
    logic [3:0] key_raw;
    logic [3:0] key_level;
    logic [3:0] key_edge;
    logic [3:0] key_press;
    logic       lock_level;
    logic       lock_edge;
    logic       lock_rise;
    logic       lock_fall;

    assign key_raw = {KeyDown, KeyUp, KeyRight, KeyLeft};

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b1)
        ) u_key_deb (
            .clock    (clock),
            .resetApp (resetApp),
            .raw_i    (key_raw[g]),
            .level_o  (key_level[g]),
            .edge_o   (key_edge[g])
        );
    end

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b0)
    ) u_lock_deb (
        .clock    (clock),
        .resetApp (resetApp),
        .raw_i    (LockSwitch),
        .level_o  (lock_level),
        .edge_o   (lock_edge)
    );

    // Keys are active-low: a press is a change to the low level.
    assign key_press = key_edge & ~key_level;
    assign lock_rise = lock_edge & lock_level;
    assign lock_fall = lock_edge & ~lock_level;

    // ---------------------------------------------------------------- state
    ctrl_state_e state_q, state_d;
    square_t     cursor_q, cursor_d;
    square_t     select_q, select_d;
    logic        select_valid_q, select_valid_d;
    logic        move_valid_q, move_valid_d;
    square_t     move_src_q, move_src_d;
    square_t     move_dst_q, move_dst_d;
    logic        player_q, player_d;

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state_q        <= IDLE;
            cursor_q       <= square_t'(CURSOR_RESET_IDX);
            select_q       <= '0;
            select_valid_q <= 1'b0;
            move_valid_q   <= 1'b0;
            move_src_q     <= '0;
            move_dst_q     <= '0;
            player_q       <= WHITE;
        end else begin
            state_q        <= state_d;
            cursor_q       <= cursor_d;
            select_q       <= select_d;
            select_valid_q <= select_valid_d;
            move_valid_q   <= move_valid_d;
            move_src_q     <= move_src_d;
            move_dst_q     <= move_dst_d;
            player_q       <= player_d;
        end
    end

    // ---------------------------------------------------------------- cursor
    logic [2:0] cur_row;
    logic [2:0] cur_col;

    assign cur_row = sq_row(cursor_q);
    assign cur_col = sq_col(cursor_q);

    // Only the highest-priority key event is consumed, even when it is clamped
    // at an edge; lower-priority events in the same cycle are dropped.
    always_comb begin
        cursor_d = cursor_q;
        if (state_q != REQUEST) begin
            if (key_press[K_LEFT]) begin
                if (cur_col != 3'd0) begin
                    cursor_d = cursor_q - square_t'(1);
                end
            end else if (key_press[K_RIGHT]) begin
                if (cur_col != EDGE_HI) begin
                    cursor_d = cursor_q + square_t'(1);
                end
            end else if (key_press[K_UP]) begin
                if (cur_row != 3'd0) begin
                    cursor_d = cursor_q - square_t'(SQUARE_WIDTH);
                end
            end else if (key_press[K_DOWN]) begin
                if (cur_row != EDGE_HI) begin
                    cursor_d = cursor_q + square_t'(SQUARE_WIDTH);
                end
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    logic own_piece;

    assign own_piece = (cursorPiece != EMPTY) && (cursorColour == player_q);

    always_comb begin
        state_d        = state_q;
        select_d       = select_q;
        select_valid_d = select_valid_q;
        move_valid_d   = move_valid_q;
        move_src_d     = move_src_q;
        move_dst_d     = move_dst_q;
        player_d       = player_q;

        unique case (state_q)
            IDLE: begin
                if (lock_rise && own_piece) begin
                    select_d       = cursor_q;
                    select_valid_d = 1'b1;
                    state_d        = SELECTED;
                end
            end

            SELECTED: begin
                if (lock_fall) begin
                    // Dropping back on the source or onto another own piece
                    // means the player changed their mind.
                    if ((cursor_q == select_q) || own_piece) begin
                        select_valid_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        move_src_d   = select_q;
                        move_dst_d   = cursor_q;
                        move_valid_d = 1'b1;
                        state_d      = REQUEST;
                    end
                end
            end

            REQUEST: begin
                if (move_valid_q && move_bus.moveReady) begin
                    move_valid_d   = 1'b0;
                    select_valid_d = 1'b0;
                    player_d       = ~player_q;
                    state_d        = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    assign cursorIdx          = cursor_q;
    assign selectIdx          = select_q;
    assign selectValid        = select_valid_q;
    assign move_bus.moveValid = move_valid_q;
    assign move_bus.moveSrc   = move_src_q;
    assign move_bus.moveDst   = move_dst_q;
    assign Player             = player_q;

endmodule

// File: tb/tb_chess_cursor_controller.sv
// tb/tb_chess_cursor_controller.sv - scoreboard bench for chess_cursor_controller

module tb_chess_cursor_controller;
    import chess_pkg::*;

    localparam logic [3:0] K_L = 4'b0001;
    localparam logic [3:0] K_R = 4'b0010;
    localparam logic [3:0] K_U = 4'b0100;
    localparam logic [3:0] K_D = 4'b1000;

    logic       clock;
    logic       resetApp;
    logic       KeyLeft, KeyUp, KeyDown, KeyRight;
    logic       LockSwitch;
    logic [2:0] cursorPiece;
    logic       cursorColour;
    logic [5:0] cursorIdx;
    logic [5:0] selectIdx;
    logic       selectValid;
    logic       Player;

    chess_cursor_controller_if bus ();

    chess_cursor_controller #(
        .DEBOUNCE_CYCLES  (4),
        .CURSOR_RESET_IDX (52)
    ) dut (
        .clock        (clock),
        .resetApp     (resetApp),
        .KeyLeft      (KeyLeft),
        .KeyUp        (KeyUp),
        .KeyDown      (KeyDown),
        .KeyRight     (KeyRight),
        .LockSwitch   (LockSwitch),
        .cursorPiece  (cursorPiece),
        .cursorColour (cursorColour),
        .cursorIdx    (cursorIdx),
        .selectIdx    (selectIdx),
        .selectValid  (selectValid),
        .move_bus     (bus),
        .Player       (Player)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] cur;
        logic [5:0] sel;
        logic       selv;
        logic       mv;
        logic [5:0] src;
        logic [5:0] dst;
        logic       pl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [5:0] m_cur, m_sel, m_src, m_dst;
    logic       m_selv, m_mv, m_pl;

    task automatic push(input int c);
        exp_t e;
        e.cyc  = c;
        e.cur  = m_cur;
        e.sel  = m_sel;
        e.selv = m_selv;
        e.mv   = m_mv;
        e.src  = m_src;
        e.dst  = m_dst;
        e.pl   = m_pl;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every visible change of the outputs must match the next expectation.
    initial begin
        logic [26:0] prev_v;
        logic [26:0] cur_v;
        exp_t        e;
        prev_v = 'x;
        forever begin
            @(negedge clock);
            cur_v = {cursorIdx, selectIdx, selectValid, bus.moveValid,
                     bus.moveSrc, bus.moveDst, Player};
            if (cur_v !== prev_v) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_change: cycle %0d cursor=%0d sel=%0d selv=%0d mv=%0d src=%0d dst=%0d player=%0d, expected no change",
                             cyc, cursorIdx, selectIdx, selectValid, bus.moveValid,
                             bus.moveSrc, bus.moveDst, Player);
                end else begin
                    e = exp_q.pop_front();
                    check("cursorIdx",   int'(cursorIdx),     int'(e.cur));
                    check("selectIdx",   int'(selectIdx),     int'(e.sel));
                    check("selectValid", int'(selectValid),   int'(e.selv));
                    check("moveValid",   int'(bus.moveValid), int'(e.mv));
                    check("moveSrc",     int'(bus.moveSrc),   int'(e.src));
                    check("moveDst",     int'(bus.moveDst),   int'(e.dst));
                    check("Player",      int'(Player),        int'(e.pl));
                    if (e.cyc >= 0) check("change_cycle", cyc, e.cyc);
                end
            end
            prev_v = cur_v;
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: %0d expected changes never seen, expected 0 outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Press a key combination cleanly; new_cur < 0 means no visible change.
    task automatic press(input logic [3:0] mask, input int new_cur);
        if (new_cur >= 0) begin
            m_cur = 6'(new_cur);
            push(cyc + 7);
        end
        {KeyDown, KeyUp, KeyRight, KeyLeft} = ~mask;
        repeat (10) @(negedge clock);
        {KeyDown, KeyUp, KeyRight, KeyLeft} = 4'hF;
        repeat (10) @(negedge clock);
        drain();
    endtask

    task automatic lock_to(input logic v);
        LockSwitch = v;
        repeat (12) @(negedge clock);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        resetApp     = 1'b1;
        {KeyDown, KeyUp, KeyRight, KeyLeft} = 4'hF;
        LockSwitch   = 1'b0;
        cursorPiece  = 3'd0;
        cursorColour = 1'b0;
        bus.moveReady = 1'b0;
        m_cur = 6'd52; m_sel = 6'd0; m_selv = 1'b0; m_mv = 1'b0;
        m_src = 6'd0;  m_dst = 6'd0; m_pl = 1'b0;
        push(-1);
        repeat (3) @(negedge clock);
        resetApp = 1'b0;
        repeat (3) @(negedge clock);
        drain();

        // Short bounce must be rejected.
        KeyLeft = 1'b0;
        repeat (3) @(negedge clock);
        KeyLeft = 1'b1;
        repeat (15) @(negedge clock);

        // Clean press: 7 edges of latency, no repeat while held.
        press(K_L, 51);

        // Walk to the top-left corner, then try to leave it.
        for (int i = 1; i <= 6; i++) press(K_U, 51 - 8 * i);
        for (int i = 1; i <= 3; i++) press(K_L, 3 - i);
        press(K_U | K_L, -1);

        // Walk to the bottom-right corner, then check clamping and priority.
        for (int i = 1; i <= 7; i++) press(K_D, 8 * i);
        for (int i = 1; i <= 7; i++) press(K_R, 56 + i);
        press(K_R | K_D, -1);
        press(K_L | K_U, 62);
        press(K_R | K_D, 63);
        press(K_U | K_D, 55);
        for (int i = 1; i <= 3; i++) press(K_L, 55 - i);

        // Opponent piece under cursor: lock is ignored both ways.
        cursorPiece = 3'd1; cursorColour = 1'b1;
        lock_to(1'b1);
        lock_to(1'b0);

        // Own piece selected then dropped on the same square: cancel.
        cursorColour = 1'b0;
        m_sel = 6'd52; m_selv = 1'b1; push(cyc + 7);
        lock_to(1'b1);
        m_selv = 1'b0; push(cyc + 7);
        lock_to(1'b0);

        // White move 52 -> 36.
        m_selv = 1'b1; push(cyc + 7);
        lock_to(1'b1);
        press(K_U, 44);
        press(K_U, 36);
        cursorPiece = 3'd0;
        m_mv = 1'b1; m_src = 6'd52; m_dst = 6'd36; push(cyc + 7);
        lock_to(1'b0);
        press(K_L, -1);
        m_mv = 1'b0; m_pl = 1'b1; m_selv = 1'b0; push(cyc + 1);
        bus.moveReady = 1'b1;
        repeat (4) @(negedge clock);
        drain();

        // Black: select 36, move onto own piece at 35 cancels (moveReady still high).
        cursorPiece = 3'd1; cursorColour = 1'b1;
        m_sel = 6'd36; m_selv = 1'b1; push(cyc + 7);
        lock_to(1'b1);
        press(K_L, 35);
        cursorPiece = 3'd6;
        m_selv = 1'b0; push(cyc + 7);
        lock_to(1'b0);

        // Black request 35 -> 43 left pending, then abandoned by reset.
        cursorPiece = 3'd2;
        m_sel = 6'd35; m_selv = 1'b1; push(cyc + 7);
        lock_to(1'b1);
        press(K_D, 43);
        bus.moveReady = 1'b0;
        cursorPiece = 3'd0;
        m_mv = 1'b1; m_src = 6'd35; m_dst = 6'd43; push(cyc + 7);
        lock_to(1'b0);
        m_cur = 6'd52; m_sel = 6'd0; m_selv = 1'b0; m_mv = 1'b0;
        m_src = 6'd0;  m_dst = 6'd0; m_pl = 1'b0;
        push(-1);
        resetApp = 1'b1;
        repeat (2) @(negedge clock);
        resetApp = 1'b0;
        repeat (4) @(negedge clock);
        drain();

        // White move with moveReady held high: request lasts exactly one cycle.
        bus.moveReady = 1'b1;
        cursorPiece = 3'd1; cursorColour = 1'b0;
        m_sel = 6'd52; m_selv = 1'b1; push(cyc + 7);
        lock_to(1'b1);
        press(K_U, 44);
        cursorPiece = 3'd0;
        m_mv = 1'b1; m_src = 6'd52; m_dst = 6'd44; push(cyc + 7);
        m_mv = 1'b0; m_pl = 1'b1; m_selv = 1'b0; push(cyc + 8);
        lock_to(1'b0);

        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/chess_cursor_controller.md
# chess_cursor_controller

Converts the raw board keys and lock switch into cursor, selection and move-request events for the chess layout matrix stage. Holds the 8x8 cursor position, the selected source square and the side to move. Issues one move request per completed source/destination selection over a valid/ready handshake, then hands the turn to the other player. Sits between the board I/O pins and the layout matrix that drives the LT24 pixel pipeline and the countdown timers.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles an input must hold a new level before it is accepted (10 ms at 50 MHz); minimum 2
- CURSOR_RESET_IDX, 52, square index loaded into the cursor at reset

Ports:
- clock  input  1  system clock
- resetApp  input  1  asynchronous, active-high reset
- KeyLeft, KeyUp, KeyDown, KeyRight  input  1 each  raw push keys, active-low, asynchronous to clock
- LockSwitch  input  1  raw slide switch, 1 = lock, asynchronous to clock
- cursorPiece  input  3  piece code at cursorIdx, returned combinationally by the layout matrix (0 = empty, 1..6 = pieces)
- cursorColour  input  1  colour of that piece (0 = white, 1 = black)
- cursorIdx  output  6  cursor square, row*8+col, row 0 at top
- selectIdx  output  6  locked source square
- selectValid  output  1  selectIdx is meaningful
- moveValid  output  1  move request pending
- moveSrc, moveDst  output  6 each  move request squares, stable while moveValid
- moveReady  input  1  layout matrix accepts the move
- Player  output  1  side to move, 0 = white, 1 = black

## Operation

- Each of the five raw inputs passes through a 2-FF synchroniser, then a debouncer. The debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Key press event: a one-cycle pulse when a debounced key goes low. Lock events: one-cycle pulses on debounced rise and fall.
- Cursor moves one square per key event and clamps at the board edges (no wrap). Left/Right change col; Up/Down change row.
- If several key events occur in the same cycle, only one is applied, with priority Left > Right > Up > Down.
- Cursor moves are ignored in REQUEST.
- States:
  - IDLE: selectValid=0. A lock rise with cursorPiece!=0 and cursorColour==Player latches selectIdx=cursorIdx and goes to SELECTED. Any other lock rise is ignored.
  - SELECTED: selectValid=1 and the cursor keeps moving. On a lock fall:
    - if cursorIdx==selectIdx, or the cursor is on a piece with cursorColour==Player, the selection is cancelled and the state returns to IDLE;
    - otherwise moveSrc=selectIdx and moveDst=cursorIdx are latched and the state goes to REQUEST.
  - REQUEST: moveValid=1, selectValid=1. On a cycle with moveValid&&moveReady, the move is transferred. On the next edge: moveValid=0, Player toggles, state goes to IDLE.
- A lock rise in SELECTED or REQUEST is ignored. A lock fall in IDLE or REQUEST is ignored.
- Reset mid-operation abandons any selection or pending request with no partial effects. The layout matrix sees moveValid drop asynchronously.

## Timing

- Reset values:
  - cursorIdx=CURSOR_RESET_IDX
  - selectIdx=0, selectValid=0
  - moveValid=0, moveSrc=0, moveDst=0
  - Player=0
  - state IDLE; debounced levels: keys 1, lock 0
- Key latency: for a clean raw edge, cursorIdx updates DEBOUNCE_CYCLES+3 clock edges after the first edge that samples the new level. The same latency applies to lock-driven state changes.
- All outputs are registered. cursorPiece and cursorColour are sampled in the same cycle as the lock event.
- Handshake:
  - moveSrc, moveDst and moveValid hold until moveReady is seen.
  - moveReady outside REQUEST is ignored.
  - moveReady may be held high permanently; the transfer then takes exactly one cycle in REQUEST.
- Player changes only on a completed transfer.

## Structure

- Shared package chess_pkg holds:
  - SQUARE_WIDTH=8, CHESS_SQUARES=64
  - piece codes (EMPTY=0, PAWN..KING=1..6)
  - colour constants WHITE=0, BLACK=1
  - the controller state enum (IDLE, SELECTED, REQUEST)
- The layout matrix and the pixel path import the same package.
- Sub-module key_debouncer (synchroniser + debounce counter + rise/fall pulses, parameter DEBOUNCE_CYCLES), instantiated five times. The FSM and cursor arithmetic live in the top module.

## Test plan

Benches run with DEBOUNCE_CYCLES=4.

- Reset, no activity -> cursorIdx=52, Player=0, moveValid=0, selectValid=0.
- KeyLeft held low for 3 cycles, then released -> cursorIdx stays 52 (bounce rejected). KeyLeft held low for 10 cycles -> cursorIdx=51 exactly 7 edges after the first low sample; no repeat while held.
- Cursor at 0, KeyUp and KeyLeft pressed -> cursorIdx stays 0. Cursor at 63, KeyRight and KeyDown pressed together -> only Right is applied, cursor clamps and stays 63.
- White move:
  - cursor 52 with cursorPiece=1, cursorColour=0; lock on -> selectIdx=52, selectValid=1.
  - two KeyUp presses -> cursorIdx=36.
  - lock off -> moveValid=1, moveSrc=52, moveDst=36.
  - moveReady held low 5 cycles -> outputs hold; moveReady=1 -> next edge moveValid=0, Player=1, selectValid=0.
- Player=0, cursor on black piece, lock on -> stays IDLE. Select own piece, lock off on the same square -> returns to IDLE, no moveValid.
- resetApp pulsed while moveValid=1 -> all outputs return to reset values, Player=0.
